// File: rtl/gb_stencil_linebuf.sv
// Line-buffered WINxWIN stencil former for the Gaussian-blur pipeline: raster pixels in, packed windows out.
// Optional build macro GB_BORDER_PASS_EN: emit a beat for every pixel, flagging non-interior ones on out_border.
module gb_stencil_linebuf #(
    parameter int IMG_W  = 488,
    parameter int IMG_H  = 648,
    parameter int WIN    = 9,
    parameter int DATA_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          in_tdata,
    input  logic                       in_tvalid,
    output logic                       in_tready,
    output logic [WIN*WIN*DATA_W-1:0]  out_stencil,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_border,
    output logic [DATA_W-1:0]          out_pix,
    output logic                       frame_done
);

    localparam int SW  = WIN * WIN * DATA_W;
    localparam int X_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int Y_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [X_W-1:0] X_LAST  = X_W'(IMG_W - 1);
    localparam logic [Y_W-1:0] Y_LAST  = Y_W'(IMG_H - 1);
    localparam logic [X_W-1:0] X_INNER = X_W'(WIN - 1);
    localparam logic [Y_W-1:0] Y_INNER = Y_W'(WIN - 1);

    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic              out_valid_q, out_valid_d;
    logic [SW-1:0]     out_stencil_q, out_stencil_d;
    logic [DATA_W-1:0] out_pix_q, out_pix_d;
    logic              frame_done_q, frame_done_d;

    // Storage that is never reset: valid gating hides whatever it holds after power-up.
    logic [DATA_W-1:0] linebuf [WIN-1][IMG_W];
    logic [SW-1:0]     win_q, win_d;
    logic [DATA_W-1:0] col [WIN];

    logic accept;
    logic x_last;
    logic y_last;
    logic interior;
    logic emit;

    assign in_tready = !out_valid_q || out_ready;
    assign accept    = in_tvalid && in_tready;
    assign x_last    = (x_q == X_LAST);
    assign y_last    = (y_q == Y_LAST);
    assign interior  = (x_q >= X_INNER) && (y_q >= Y_INNER);

`ifdef GB_BORDER_PASS_EN
    logic out_border_q, out_border_d;
    assign emit       = accept;
    assign out_border = out_border_q;
`else
    assign emit       = accept && interior;
    assign out_border = 1'b0;
`endif

    assign out_valid   = out_valid_q;
    assign out_stencil = out_stencil_q;
    assign out_pix     = out_pix_q;
    assign frame_done  = frame_done_q;

    always_comb begin
        for (int r = 0; r < WIN - 1; r++) begin
            col[r] = linebuf[r][x_q];
        end
        col[WIN-1] = in_tdata;
    end

    // Shift the window left one column; the incoming column lands in column WIN-1.
    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int r = 0; r < WIN; r++) begin
                for (int c = 0; c < WIN - 1; c++) begin
                    win_d[(r*WIN+c)*DATA_W +: DATA_W] = win_q[(r*WIN+c+1)*DATA_W +: DATA_W];
                end
                win_d[(r*WIN+WIN-1)*DATA_W +: DATA_W] = col[r];
            end
        end
    end

    always_comb begin
        x_d          = x_q;
        y_d          = y_q;
        frame_done_d = accept && x_last && y_last;
        if (accept) begin
            if (x_last) begin
                x_d = '0;
                y_d = y_last ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    // A newly loaded beat wins over draining; otherwise a consumed beat clears valid.
    always_comb begin
        out_valid_d   = out_valid_q;
        out_stencil_d = out_stencil_q;
        out_pix_d     = out_pix_q;
`ifdef GB_BORDER_PASS_EN
        out_border_d  = out_border_q;
`endif
        if (emit) begin
            out_valid_d   = 1'b1;
            out_stencil_d = win_d;
            out_pix_d     = in_tdata;
`ifdef GB_BORDER_PASS_EN
            out_border_d  = !interior;
`endif
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q           <= '0;
            y_q           <= '0;
            out_valid_q   <= 1'b0;
            out_stencil_q <= '0;
            out_pix_q     <= '0;
            frame_done_q  <= 1'b0;
`ifdef GB_BORDER_PASS_EN
            out_border_q  <= 1'b0;
`endif
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            out_valid_q   <= out_valid_d;
            out_stencil_q <= out_stencil_d;
            out_pix_q     <= out_pix_d;
            frame_done_q  <= frame_done_d;
`ifdef GB_BORDER_PASS_EN
            out_border_q  <= out_border_d;
`endif
        end
    end

    // Each accepted pixel pushes its column one line up through the buffers.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < WIN - 2; r++) begin
                linebuf[r][x_q] <= linebuf[r+1][x_q];
            end
            linebuf[WIN-2][x_q] <= in_tdata;
        end
        win_q <= win_d;
    end

endmodule

// File: tb/tb_gb_stencil_linebuf.sv
// Randomised self-checking bench for gb_stencil_linebuf on a 12x10 image with a 9x9 window.
// Expected stencils are cut directly out of a stored frame image; honours GB_BORDER_PASS_EN.
module tb_gb_stencil_linebuf;

    localparam int IMG_W  = 12;
    localparam int IMG_H  = 10;
    localparam int WIN    = 9;
    localparam int DATA_W = 8;
    localparam int NPIX   = IMG_W * IMG_H;
    localparam int SW     = WIN * WIN * DATA_W;
    localparam int BUDGET = 20000;
`ifdef GB_BORDER_PASS_EN
    localparam int BEATS_PER_FRAME = NPIX;
`else
    localparam int BEATS_PER_FRAME = (IMG_W - WIN + 1) * (IMG_H - WIN + 1);
`endif

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] in_tdata;
    logic              in_tvalid;
    logic              in_tready;
    logic [SW-1:0]     out_stencil;
    logic              out_valid;
    logic              out_ready;
    logic              out_border;
    logic [DATA_W-1:0] out_pix;
    logic              frame_done;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] frame [NPIX];
    logic [SW-1:0]     exp_st_q   [$];
    logic [DATA_W-1:0] exp_pix_q  [$];
    logic              exp_bord_q [$];

    gb_stencil_linebuf #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .WIN    (WIN),
        .DATA_W (DATA_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_tdata    (in_tdata),
        .in_tvalid   (in_tvalid),
        .in_tready   (in_tready),
        .out_stencil (out_stencil),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_border  (out_border),
        .out_pix     (out_pix),
        .frame_done  (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] expv);
        n_checks++;
        assert (obs === expv) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic fillFrame(input bit ramp);
        for (int i = 0; i < NPIX; i++) begin
            frame[i] = ramp ? DATA_W'(i % 256) : DATA_W'($urandom);
        end
    endtask

    // Every interior pixel's stencil is the WINxWIN block of the image ending at that pixel.
    task automatic modelFrame();
        for (int y = 0; y < IMG_H; y++) begin
            for (int x = 0; x < IMG_W; x++) begin
                logic [SW-1:0] st;
                bit inner;
                inner = (x >= WIN - 1) && (y >= WIN - 1);
                st = '0;
                if (inner) begin
                    for (int r = 0; r < WIN; r++) begin
                        for (int c = 0; c < WIN; c++) begin
                            st[(r*WIN+c)*DATA_W +: DATA_W] = frame[(y-(WIN-1)+r)*IMG_W + (x-(WIN-1)+c)];
                        end
                    end
                end
`ifndef GB_BORDER_PASS_EN
                if (!inner) continue;
`endif
                exp_st_q.push_back(st);
                exp_pix_q.push_back(frame[y*IMG_W + x]);
                exp_bord_q.push_back(!inner);
            end
        end
    endtask

    task automatic applyStimulus(input int n_frames, input int valid_pct, input int ready_pct,
                                 input int hold_cycles, input int stop_at);
        int  limit;
        int  sent;
        int  cyc;
        int  beats;
        int  hold_left;
        int  frames_seen;
        bit  holding;
        limit       = (stop_at > 0) ? stop_at : n_frames * NPIX;
        sent        = 0;
        cyc         = 0;
        beats       = 0;
        hold_left   = hold_cycles;
        frames_seen = 0;
        for (int f = 0; f < n_frames; f++) modelFrame();
        while (((sent < limit) || (stop_at == 0 && exp_st_q.size() > 0)) && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            if (frame_done) frames_seen++;
            in_tvalid = (sent < limit) && ($urandom_range(99) < valid_pct);
            in_tdata  = frame[sent % NPIX];
            holding   = (hold_left > 0) && out_valid;
            if (holding) begin
                out_ready = 1'b0;
                hold_left--;
            end else begin
                out_ready = ($urandom_range(99) < ready_pct);
            end
            #1;
            if (holding) begin
                checkOutput("hold_tready", SW'(in_tready), SW'(1'b0));
                if (exp_st_q.size() > 0 && !exp_bord_q[0])
                    checkOutput("hold_stencil", out_stencil, exp_st_q[0]);
            end
            if (out_valid && out_ready) begin
                checkOutput("beat_expected", SW'(exp_st_q.size() > 0), SW'(1'b1));
                if (exp_st_q.size() > 0) begin
                    logic [SW-1:0]     st;
                    logic [DATA_W-1:0] px;
                    logic              bd;
                    st = exp_st_q.pop_front();
                    px = exp_pix_q.pop_front();
                    bd = exp_bord_q.pop_front();
                    checkOutput("beat_border", SW'(out_border), SW'(bd));
                    checkOutput("beat_pix", SW'(out_pix), SW'(px));
                    if (!bd) checkOutput("beat_stencil", out_stencil, st);
                end
                beats++;
            end
            if (in_tvalid && in_tready) sent++;
        end
        if (stop_at == 0) begin
            checkOutput("drained_in_budget", SW'(exp_st_q.size()), SW'(0));
            checkOutput("beat_count", SW'(beats), SW'(n_frames * BEATS_PER_FRAME));
            checkOutput("frame_done_count", SW'(frames_seen), SW'(n_frames));
        end else begin
            checkOutput("partial_in_budget", SW'(sent), SW'(limit));
        end
    endtask

    initial begin
        rst       = 1'b0;
        in_tvalid = 1'b0;
        in_tdata  = '0;
        out_ready = 1'b0;
        #2;
        checkOutput("rst_valid", SW'(out_valid), SW'(1'b0));
        checkOutput("rst_border", SW'(out_border), SW'(1'b0));
        checkOutput("rst_frame_done", SW'(frame_done), SW'(1'b0));
        checkOutput("rst_stencil", out_stencil, '0);
        checkOutput("rst_pix", SW'(out_pix), SW'(0));
        checkOutput("rst_tready", SW'(in_tready), SW'(1'b1));
        #20 rst = 1'b1;

        $display("[TB] full ramp frame, consumer always ready");
        fillFrame(1'b1);
        applyStimulus(1, 100, 100, 0, 0);

        $display("[TB] consumer stalls 20 cycles at first beat");
        fillFrame(1'b0);
        applyStimulus(1, 100, 100, 20, 0);

        $display("[TB] random valid and ready");
        fillFrame(1'b1);
        applyStimulus(1, 50, 50, 0, 0);

        $display("[TB] two back-to-back frames");
        fillFrame(1'b0);
        applyStimulus(2, 100, 100, 0, 0);

        $display("[TB] reset mid-line with a pending beat");
        fillFrame(1'b1);
        applyStimulus(1, 100, 100, 0, 8 * IMG_W + 10);
        @(negedge clk);
        in_tvalid = 1'b0;
        out_ready = 1'b0;
        #1;
        checkOutput("pre_reset_valid", SW'(out_valid), SW'(1'b1));
        if (exp_st_q.size() > 0 && !exp_bord_q[0])
            checkOutput("pre_reset_stencil", out_stencil, exp_st_q[0]);
        #2 rst = 1'b0;
        #1;
        checkOutput("async_rst_valid", SW'(out_valid), SW'(1'b0));
        checkOutput("async_rst_stencil", out_stencil, '0);
        checkOutput("async_rst_pix", SW'(out_pix), SW'(0));
        checkOutput("async_rst_frame_done", SW'(frame_done), SW'(1'b0));
        checkOutput("async_rst_tready", SW'(in_tready), SW'(1'b1));
        exp_st_q.delete();
        exp_pix_q.delete();
        exp_bord_q.delete();
        #3 rst = 1'b1;

        $display("[TB] full frame after mid-frame reset");
        fillFrame(1'b0);
        applyStimulus(1, 100, 100, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
